// File: rtl/mem.sv
// Shared memory-access definitions used by requesters and the bus arbiter.
package mem;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        WORD  = 2'd1,
        DWORD = 2'd2
    } width_t;

endpackage

// File: rtl/mem_bus_arbiter_pkg.sv
// Arbiter FSM states and the per-port pending request record.
package ProcTypes;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT
    } arb_state_t;

    typedef struct packed {
        logic         write;
        logic [31:0]  addr;
        mem::width_t  width;
        logic [31:0]  data;
    } slot_t;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin grant: on contention the port not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] pending,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    always_comb begin
        valid = |pending;
        grant = 1'b0;
        if (pending == 2'b11)
            grant = ~last_grant;
        else if (pending[1])
            grant = 1'b1;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: latches one request per port and serves
// them round-robin through a single downstream bus with a WAIT timeout.
module mem_bus_arbiter
    import ProcTypes::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rq0_dispatch_read,
    input  logic        rq0_dispatch_write,
    input  logic [31:0] rq0_addr,
    input  mem::width_t rq0_mem_width,
    input  logic [31:0] rq0_write_data,
    output logic [31:0] rq0_read_data,
    output logic        rq0_busy,
    input  logic        rq1_dispatch_read,
    input  logic        rq1_dispatch_write,
    input  logic [31:0] rq1_addr,
    input  mem::width_t rq1_mem_width,
    input  logic [31:0] rq1_write_data,
    output logic [31:0] rq1_read_data,
    output logic        rq1_busy,
    output logic        mem_dispatch_read,
    output logic        mem_dispatch_write,
    output logic [31:0] mem_addr,
    output mem::width_t mem_mem_width,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_busy,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    dsp_rd;
    logic [1:0]    dsp_wr;
    slot_t         dsp_slot [2];
    slot_t         slot_q   [2];
    logic [1:0]    pend_q;
    logic          last_q;
    logic          cur_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q  [2];
    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          gnt_valid;
    logic          gnt;
    logic          grant_en;
    logic          done;
    logic          abort;

    assign dsp_rd      = {rq1_dispatch_read, rq0_dispatch_read};
    assign dsp_wr      = {rq1_dispatch_write, rq0_dispatch_write};
    assign dsp_slot[0] = '{rq0_dispatch_write, rq0_addr,
                           rq0_mem_width, rq0_write_data};
    assign dsp_slot[1] = '{rq1_dispatch_write, rq1_addr,
                           rq1_mem_width, rq1_write_data};

    assign rq0_busy      = pend_q[0];
    assign rq1_busy      = pend_q[1];
    assign rq0_read_data = rdata_q[0];
    assign rq1_read_data = rdata_q[1];

    rr_arbiter2 u_rr (
        .pending    (pend_q),
        .last_grant (last_q),
        .valid      (gnt_valid),
        .grant      (gnt)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid && !mem_busy) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE:  state_d = SETTLE;
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (!mem_busy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_q             <= '0;
            slot_q[0]          <= '0;
            slot_q[1]          <= '0;
            rdata_q[0]         <= '0;
            rdata_q[1]         <= '0;
            last_q             <= 1'b1;
            cur_q              <= 1'b0;
            cnt_q              <= '0;
            err                <= 1'b0;
            mem_dispatch_read  <= 1'b0;
            mem_dispatch_write <= 1'b0;
            mem_addr           <= '0;
            mem_mem_width      <= mem::BYTE;
            mem_write_data     <= '0;
        end else begin
            mem_dispatch_read  <= 1'b0;
            mem_dispatch_write <= 1'b0;
            if (grant_en) begin
                cur_q              <= gnt;
                last_q             <= gnt;
                mem_addr           <= slot_q[gnt].addr;
                mem_mem_width      <= slot_q[gnt].width;
                mem_write_data     <= slot_q[gnt].data;
                mem_dispatch_read  <= ~slot_q[gnt].write;
                mem_dispatch_write <= slot_q[gnt].write;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
            if (done || abort)
                pend_q[cur_q] <= 1'b0;
            if (done && !slot_q[cur_q].write)
                rdata_q[cur_q] <= mem_read_data;
            if (abort)
                err <= 1'b1;
            // A busy port drops the new request; the in-flight one is untouched.
            for (int n = 0; n < 2; n++) begin
                if (dsp_rd[n] || dsp_wr[n]) begin
                    if (pend_q[n]) begin
                        err <= 1'b1;
                    end else begin
                        pend_q[n] <= 1'b1;
                        slot_q[n] <= dsp_slot[n];
                    end
                    if (dsp_rd[n] && dsp_wr[n])
                        err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a
// transaction-timeline model of the arbitration rules.
module tb_mem_bus_arbiter;
    import mem::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rq_rd [2];
    logic        rq_wr [2];
    logic [31:0] rq_addr [2];
    width_t      rq_w [2];
    logic [31:0] rq_data [2];
    logic [31:0] rq_rdata [2];
    logic        rq_busy [2];
    logic        mem_dispatch_read;
    logic        mem_dispatch_write;
    logic [31:0] mem_addr;
    width_t      mem_mem_width;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_busy;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in             (clk),
        .rst_in             (rst_in),
        .rq0_dispatch_read  (rq_rd[0]),
        .rq0_dispatch_write (rq_wr[0]),
        .rq0_addr           (rq_addr[0]),
        .rq0_mem_width      (rq_w[0]),
        .rq0_write_data     (rq_data[0]),
        .rq0_read_data      (rq_rdata[0]),
        .rq0_busy           (rq_busy[0]),
        .rq1_dispatch_read  (rq_rd[1]),
        .rq1_dispatch_write (rq_wr[1]),
        .rq1_addr           (rq_addr[1]),
        .rq1_mem_width      (rq_w[1]),
        .rq1_write_data     (rq_data[1]),
        .rq1_read_data      (rq_rdata[1]),
        .rq1_busy           (rq_busy[1]),
        .mem_dispatch_read  (mem_dispatch_read),
        .mem_dispatch_write (mem_dispatch_write),
        .mem_addr           (mem_addr),
        .mem_mem_width      (mem_mem_width),
        .mem_write_data     (mem_write_data),
        .mem_read_data      (mem_read_data),
        .mem_busy           (mem_busy),
        .err                (err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: a request is granted from idle, strobed the next cycle,
    // then after one settle cycle waits for mem_busy low or the timeout.
    bit          m_on = 0;
    bit          m_pend [2];
    bit          m_wr [2];
    logic [31:0] m_addr [2];
    width_t      m_w [2];
    logic [31:0] m_data [2];
    logic [31:0] m_rd [2];
    bit          m_err;
    int          m_last;
    int          m_srv;
    int          m_age;
    logic [31:0] m_maddr;
    width_t      m_mw;
    logic [31:0] m_mwd;
    bit          m_sr;
    bit          m_sw;

    always @(posedge clk) begin
        bit pre [2];
        int pick;
        if (rst_in) begin
            m_on = 1;
            for (int n = 0; n < 2; n++) begin
                m_pend[n] = 0;
                m_rd[n]   = '0;
            end
            m_err = 0; m_last = 1; m_srv = -1; m_age = 0;
            m_maddr = '0; m_mw = BYTE; m_mwd = '0;
            m_sr = 0; m_sw = 0;
        end else if (m_on) begin
            pre[0] = m_pend[0];
            pre[1] = m_pend[1];
            m_sr = 0;
            m_sw = 0;
            if (m_srv < 0) begin
                if ((pre[0] || pre[1]) && !mem_busy) begin
                    pick = (pre[0] && pre[1]) ? 1 - m_last : (pre[0] ? 0 : 1);
                    m_srv = pick; m_age = 1; m_last = pick;
                    m_maddr = m_addr[pick]; m_mw = m_w[pick];
                    m_mwd = m_data[pick];
                    m_sr = !m_wr[pick]; m_sw = m_wr[pick];
                end
            end else if (m_age < 3) begin
                m_age++;
            end else if (!mem_busy) begin
                if (!m_wr[m_srv]) m_rd[m_srv] = mem_read_data;
                m_pend[m_srv] = 0;
                m_srv = -1;
            end else if (m_age - 2 == TO) begin
                m_pend[m_srv] = 0;
                m_err = 1;
                m_srv = -1;
            end else begin
                m_age++;
            end
            for (int n = 0; n < 2; n++) begin
                if (rq_rd[n] || rq_wr[n]) begin
                    if (pre[n]) begin
                        m_err = 1;
                    end else begin
                        m_pend[n] = 1; m_wr[n] = rq_wr[n];
                        m_addr[n] = rq_addr[n]; m_w[n] = rq_w[n];
                        m_data[n] = rq_data[n];
                    end
                    if (rq_rd[n] && rq_wr[n]) m_err = 1;
                end
            end
        end
        #1;
        if (m_on) begin
            chk("busy0", 32'(rq_busy[0]), 32'(m_pend[0]));
            chk("busy1", 32'(rq_busy[1]), 32'(m_pend[1]));
            chk("rdata0", rq_rdata[0], m_rd[0]);
            chk("rdata1", rq_rdata[1], m_rd[1]);
            chk("err", 32'(err), 32'(m_err));
            chk("strobe_rd", 32'(mem_dispatch_read), 32'(m_sr));
            chk("strobe_wr", 32'(mem_dispatch_write), 32'(m_sw));
            chk("mem_addr", mem_addr, m_maddr);
            chk("mem_width", 32'(mem_mem_width), 32'(m_mw));
            chk("mem_wdata", mem_write_data, m_mwd);
        end
    end

    task automatic clr_disp();
        for (int n = 0; n < 2; n++) begin
            rq_rd[n] = 0;
            rq_wr[n] = 0;
        end
    endtask

    task automatic disp(input int n, input bit r, input bit w,
                        input logic [31:0] a, input width_t wd,
                        input logic [31:0] d);
        rq_rd[n] = r; rq_wr[n] = w;
        rq_addr[n] = a; rq_w[n] = wd; rq_data[n] = d;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        clr_disp();
        mem_busy = 0;
        rst_in = 1;
        @(negedge clk);
        rst_in = 0;
    endtask

    int cnt;

    initial begin
        rst_in = 1;
        mem_busy = 0;
        mem_read_data = '0;
        for (int n = 0; n < 2; n++) begin
            rq_addr[n] = '0; rq_w[n] = BYTE; rq_data[n] = '0;
        end
        clr_disp();
        cyc(2);
        rst_in = 0;

        // Single read, minimum latency
        do_reset();
        mem_read_data = 32'hDEADBEEF;
        disp(0, 1, 0, 32'h100, WORD, '0);
        cyc(1); clr_disp();
        chk("s1_busy_c1", 32'(rq_busy[0]), 1);
        cyc(1);
        chk("s1_strobe_c2", 32'(mem_dispatch_read), 1);
        chk("s1_addr_c2", mem_addr, 32'h100);
        cyc(2);
        chk("s1_busy_c4", 32'(rq_busy[0]), 1);
        cyc(1);
        chk("s1_rdata_c5", rq_rdata[0], 32'hDEADBEEF);
        chk("s1_busy_c5", 32'(rq_busy[0]), 0);

        // Simultaneous requests, round-robin order
        do_reset();
        mem_read_data = 32'hA0A00000;
        disp(0, 1, 0, 32'h200, WORD, '0);
        disp(1, 1, 0, 32'h300, BYTE, '0);
        cyc(1); clr_disp();
        cyc(1);
        chk("s2_first_addr", mem_addr, 32'h200);
        cyc(3);
        chk("s2_rd0", rq_rdata[0], 32'hA0A00000);
        chk("s2_busy1_wait", 32'(rq_busy[1]), 1);
        mem_read_data = 32'hB1B11111;
        cyc(1);
        chk("s2_second_strobe", 32'(mem_dispatch_read), 1);
        chk("s2_second_addr", mem_addr, 32'h300);
        cyc(3);
        chk("s2_rd1", rq_rdata[1], 32'hB1B11111);
        disp(0, 0, 1, 32'h400, WORD, 32'h11);
        disp(1, 0, 1, 32'h500, WORD, 32'h22);
        cyc(1); clr_disp();
        cyc(1);
        chk("s2_again_strobe", 32'(mem_dispatch_write), 1);
        chk("s2_again_addr", mem_addr, 32'h400);
        cyc(8);
        chk("s2_all_idle", {30'd0, rq_busy[1], rq_busy[0]}, 0);

        // Write with a long busy response
        disp(1, 0, 1, 32'h600, DWORD, 32'h12345678);
        cnt = 0;
        cyc(1); clr_disp();
        cyc(1);
        mem_busy = 1;
        chk("s3_wdata", mem_write_data, 32'h12345678);
        for (int k = 2; k < 12; k++) begin
            cnt += int'(mem_dispatch_write);
            cyc(1);
        end
        mem_busy = 0;
        chk("s3_busy_c12", 32'(rq_busy[1]), 1);
        cyc(1);
        chk("s3_busy_c13", 32'(rq_busy[1]), 0);
        chk("s3_one_strobe", 32'(cnt), 1);
        chk("s3_rd1_kept", rq_rdata[1], 32'hB1B11111);

        // Dispatch to a busy port is dropped
        do_reset();
        mem_read_data = 32'hCAFEF00D;
        disp(0, 1, 0, 32'h700, WORD, '0);
        cyc(1); clr_disp();
        cyc(1);
        disp(0, 1, 0, 32'h800, WORD, '0);
        cyc(1); clr_disp();
        chk("s4_err", 32'(err), 1);
        cyc(2);
        chk("s4_rd0", rq_rdata[0], 32'hCAFEF00D);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            cnt += int'(mem_dispatch_read) + int'(rq_busy[0]);
            cyc(1);
        end
        chk("s4_no_replay", 32'(cnt), 0);

        // Timeout with mem_busy stuck high
        do_reset();
        disp(0, 1, 0, 32'h900, WORD, '0);
        cyc(1); clr_disp();
        cyc(1);
        mem_busy = 1;
        cyc(17);
        chk("s5_busy_c19", 32'(rq_busy[0]), 1);
        chk("s5_err_c19", 32'(err), 0);
        cyc(1);
        chk("s5_busy_c20", 32'(rq_busy[0]), 0);
        chk("s5_err_c20", 32'(err), 1);
        chk("s5_rd0", rq_rdata[0], 0);
        mem_busy = 0;

        // Reset during WAIT
        do_reset();
        disp(0, 1, 0, 32'hA00, WORD, '0);
        cyc(1); clr_disp();
        cyc(1);
        mem_busy = 1;
        cyc(3);
        rst_in = 1;
        cyc(1);
        rst_in = 0;
        chk("s6_outs_zero",
            {mem_addr | mem_write_data | rq_rdata[0] | rq_rdata[1]}, 0);
        chk("s6_flags_zero",
            {26'd0, mem_dispatch_read, mem_dispatch_write, rq_busy[0],
             rq_busy[1], err, |mem_mem_width}, 0);
        mem_busy = 0;
        mem_read_data = 32'h5A5A5A5A;
        disp(1, 1, 0, 32'hB00, WORD, '0);
        cyc(1); clr_disp();
        cyc(4);
        chk("s6_rd1", rq_rdata[1], 32'h5A5A5A5A);
        chk("s6_busy1", 32'(rq_busy[1]), 0);

        // Randomized traffic
        do_reset();
        cnt = 0;
        for (int k = 0; k < 4000; k++) begin
            clr_disp();
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 5) == 0) begin
                    int kind = $urandom_range(0, 9);
                    disp(n, kind != 9 && kind < 5, kind >= 5,
                         $urandom, width_t'($urandom_range(0, 2)), $urandom);
                end
            end
            if (cnt > 0) begin
                cnt--;
                mem_busy = 1;
            end else begin
                mem_busy = ($urandom_range(0, 9) < 3);
                if ($urandom_range(0, 199) == 0) cnt = 25;
            end
            mem_read_data = $urandom;
            rst_in = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        clr_disp();
        rst_in = 0;
        mem_busy = 0;
        cyc(30);
        chk("rand_drained", {30'd0, rq_busy[1], rq_busy[0]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
